bus_arbiter: RTL



---
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/bus_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface: requesters ask for the shared datapath bus and
// name a source code; the arbiter returns a grant and drives the mux select.
//
// Handshake: req[i] is a level. Requester i raises it to ask for the bus and
// holds it for as long as it wants the bus. gnt[i] is the registered answer.
// Dropping req[i] while gnt[i] is high ends the tenure on the next edge.
// src[5i+4:5i] is sampled only on the edge that issues gnt[i].
interface bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [5*NUM_REQ-1:0] src;
  logic [NUM_REQ-1:0]   gnt;
  logic [4:0]           bus_select;
  logic                 bus_busy;
  logic                 src_err;

  // Requester side.
  modport master (
    output req, src,
    input  gnt, bus_select, bus_busy, src_err
  );

  // Arbiter side.
  modport slave (
    input  req, src,
    output gnt, bus_select, bus_busy, src_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a bounded tenure. One grant at a time, an idle
// turnaround cycle between tenures, and an idle mux code whenever nobody owns
// the bus or the owner asked for a source outside the valid range.
module bus_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  parameter  int IDLE_SEL = 31,
  localparam int HW       = $clog2(MAX_HOLD + 1),
  localparam int PW       = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          clr,
  bus_arbiter_if.slave  bus,
  output logic          state_dbg,     // 0 = IDLE, 1 = GRANT
  output logic [HW-1:0] hold_cnt_dbg
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [4:0]    IDLE_CODE = 5'(IDLE_SEL);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [4:0]    LAST_OK   = 5'd23;

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [HW-1:0]        hold_cnt;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [4:0]           sel_r;
  logic                 busy_r;
  logic                 err_r;

  logic                 any_req;
  logic [PW-1:0]        winner;
  logic [4:0]           winner_src;
  logic                 owner_req;
  logic                 others_req;

  // Scan from rr_ptr upward; iterating the offsets downward lets the
  // nearest pending requester overwrite any farther one.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        winner  = PW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign winner_src = bus.src[int'(winner) * 5 +: 5];
  assign owner_req  = |(bus.req & gnt_r);
  assign others_req = |(bus.req & ~gnt_r);

  // Arbitration FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt_r    <= '0;
      sel_r    <= IDLE_CODE;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          err_r <= 1'b0;
          if (any_req) begin
            state    <= S_GRANT;
            gnt_r    <= NUM_REQ'(1) << winner;
            busy_r   <= 1'b1;
            hold_cnt <= HW'(1);
            rr_ptr   <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
            // An out-of-range code still gets the bus, but the mux stays idle.
            if (winner_src > LAST_OK) begin
              sel_r <= IDLE_CODE;
              err_r <= 1'b1;
            end else begin
              sel_r <= winner_src;
            end
          end
        end
        S_GRANT: begin
          err_r <= 1'b0;
          if (!owner_req || (hold_cnt == HOLD_MAX && others_req)) begin
            state    <= S_IDLE;
            gnt_r    <= '0;
            sel_r    <= IDLE_CODE;
            busy_r   <= 1'b0;
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.bus_select = sel_r;
  assign bus.bus_busy   = busy_r;
  assign bus.src_err    = err_r;
  assign state_dbg      = state;
  assign hold_cnt_dbg   = hold_cnt;

endmodule
